max7219_chain: RTL



---
 rtl/max7219_chain.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/max7219_chain.sv
// Drives a daisy-chain of MAX7219 controllers with signed decimal values over bit-banged SPI.
// Free-running after reset, all SPI edges are paced by the divider tick, and there is no host handshake or backpressure.
module max7219_chain #(
  parameter int CHIPS       = 1,
  parameter int DIGITS      = 8,
  parameter int VALUE_WIDTH = 24,
  parameter int DIVIDER     = 22,
  parameter int DP_POS      = 2,
  parameter int BLANK_LZ    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHIPS*VALUE_WIDTH-1:0] value,
  input  logic [3:0]                   brightness,
  output logic                         mosi,
  output logic                         sclk,
  output logic                         sel,
  output logic                         busy
);
  localparam int FW   = 16*CHIPS;
  localparam int NB   = DIGITS-1;
  localparam int DIVW = (DIVIDER > 0) ? $clog2(DIVIDER+1) : 1;
  localparam int TW   = $clog2(32*CHIPS+3);
  localparam int CW   = $clog2(VALUE_WIDTH+1);
  localparam logic [63:0] LIMIT = 64'(10**NB) - 64'd1;

  typedef enum logic [1:0] {ST_INIT, ST_CONV, ST_SWEEP, ST_BRT} state_t;
  state_t r_state, w_state_nxt;

  logic [DIVW-1:0]        r_div;
  logic                   r_active;
  logic [TW-1:0]          r_tcnt;
  logic [FW-1:0]          r_shift;
  logic [2:0]             r_init_idx;
  logic [2:0]             r_digit;
  logic [7:0]             r_sweeps;
  logic [3:0]             r_bright_sent;
  logic [CW-1:0]          r_conv_cnt;
  logic                   r_mosi, r_sclk, r_sel, r_busy;
  logic [VALUE_WIDTH-1:0] r_mag [CHIPS];
  logic [4*NB-1:0]        r_bcd [CHIPS];
  logic [CHIPS-1:0]       r_neg, r_ovf;

  logic                   w_tick, w_fstart, w_fdone, w_conv_done, w_last_digit;
  logic [VALUE_WIDTH-1:0] w_val [CHIPS];
  logic [VALUE_WIDTH-1:0] w_abs [CHIPS];
  logic [CHIPS-1:0]       w_big;
  logic [4*NB-1:0]        w_bcd_adj [CHIPS];
  logic [4*NB-1:0]        w_tail [CHIPS];
  logic [7:0]             w_seg [CHIPS];
  logic [15:0]            w_init_word;
  logic [FW-1:0]          w_frame;

  function automatic logic [7:0] f_seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0: s = 8'h7E;
      4'd1: s = 8'h30;
      4'd2: s = 8'h6D;
      4'd3: s = 8'h79;
      4'd4: s = 8'h33;
      4'd5: s = 8'h5B;
      4'd6: s = 8'h5F;
      4'd7: s = 8'h70;
      4'd8: s = 8'h7F;
      4'd9: s = 8'h7B;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign w_tick       = (r_div == DIVW'(DIVIDER));
  assign w_fstart     = w_tick && !r_active && (r_state != ST_CONV);
  assign w_fdone      = w_tick && r_active && (r_tcnt == TW'(32*CHIPS+1));
  assign w_conv_done  = (r_state == ST_CONV) && (r_conv_cnt == CW'(VALUE_WIDTH));
  assign w_last_digit = (r_digit == 3'(DIGITS-1));

  always_ff @(posedge clk) begin
    if (!rst_n || w_tick) r_div <= '0;
    else                  r_div <= r_div + DIVW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // A full 256-sweep period re-runs INIT, which also refreshes intensity.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (w_fdone && r_init_idx == 3'd4) w_state_nxt = ST_CONV;
      ST_CONV:  if (w_conv_done) w_state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        if (w_fdone && w_last_digit) begin
          if (r_sweeps == 8'hFF)                  w_state_nxt = ST_INIT;
          else if (brightness != r_bright_sent)   w_state_nxt = ST_BRT;
          else                                    w_state_nxt = ST_CONV;
        end
      end
      ST_BRT:   if (w_fdone) w_state_nxt = ST_CONV;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_idx    <= '0;
      r_digit       <= '0;
      r_sweeps      <= '0;
      r_bright_sent <= '0;
    end else begin
      if (w_fstart && (r_state == ST_BRT || (r_state == ST_INIT && r_init_idx == 3'd1)))
        r_bright_sent <= brightness;
      if (w_fdone) begin
        if (r_state == ST_INIT) begin
          r_init_idx <= (r_init_idx == 3'd4) ? 3'd0 : r_init_idx + 3'd1;
        end else if (r_state == ST_SWEEP) begin
          if (w_last_digit) begin
            r_digit  <= '0;
            r_sweeps <= r_sweeps + 8'd1;
          end else begin
            r_digit  <= r_digit + 3'd1;
          end
        end
      end
    end
  end

  // Two's-complement negate in VALUE_WIDTH bits yields the correct unsigned magnitude even for the most negative value.
  always_comb begin
    for (int c = 0; c < CHIPS; c++) begin
      w_val[c] = value[c*VALUE_WIDTH +: VALUE_WIDTH];
      w_abs[c] = w_val[c][VALUE_WIDTH-1] ? (~w_val[c] + VALUE_WIDTH'(1)) : w_val[c];
      w_big[c] = (64'(w_abs[c]) > LIMIT);
      w_bcd_adj[c] = r_bcd[c];
      for (int d = 0; d < NB; d++) begin
        if (r_bcd[c][4*d +: 4] >= 4'd5) w_bcd_adj[c][4*d +: 4] = r_bcd[c][4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conv_cnt <= '0;
      r_neg      <= '0;
      r_ovf      <= '0;
      for (int c = 0; c < CHIPS; c++) begin
        r_mag[c] <= '0;
        r_bcd[c] <= '0;
      end
    end else if (r_state == ST_CONV) begin
      r_conv_cnt <= w_conv_done ? '0 : r_conv_cnt + CW'(1);
      for (int c = 0; c < CHIPS; c++) begin
        if (r_conv_cnt == '0) begin
          r_neg[c] <= w_val[c][VALUE_WIDTH-1];
          r_ovf[c] <= w_big[c];
          r_mag[c] <= w_abs[c];
          r_bcd[c] <= '0;
        end else begin
          {r_bcd[c], r_mag[c]} <= {w_bcd_adj[c], r_mag[c]} << 1;
        end
      end
    end
  end

  // A position is a leading zero when it and every higher magnitude digit are zero.
  always_comb begin
    for (int c = 0; c < CHIPS; c++) begin
      w_tail[c] = r_bcd[c] >> {r_digit, 2'b00};
      w_seg[c]  = 8'h00;
      if (r_ovf[c])
        w_seg[c] = 8'h01;
      else if (r_digit == 3'(NB))
        w_seg[c] = r_neg[c] ? 8'h01 : 8'h00;
      else if (BLANK_LZ != 0 && int'(r_digit) >= DP_POS && r_digit != 3'd0 && w_tail[c] == '0)
        w_seg[c] = 8'h00;
      else
        w_seg[c] = f_seg7(w_tail[c][3:0]) | ((int'(r_digit) == DP_POS - 1) ? 8'h80 : 8'h00);
    end
  end

  always_comb begin
    case (r_init_idx)
      3'd0:    w_init_word = 16'h0900;
      3'd1:    w_init_word = {8'h0A, 4'h0, brightness};
      3'd2:    w_init_word = {8'h0B, 8'(DIGITS-1)};
      3'd3:    w_init_word = 16'h0C01;
      default: w_init_word = 16'h0F00;
    endcase
    w_frame = '0;
    for (int c = 0; c < CHIPS; c++) begin
      case (r_state)
        ST_SWEEP: w_frame[c*16 +: 16] = {4'h0, {1'b0, r_digit} + 4'd1, w_seg[c]};
        ST_BRT:   w_frame[c*16 +: 16] = {8'h0A, 4'h0, brightness};
        default:  w_frame[c*16 +: 16] = w_init_word;
      endcase
    end
  end

  // Highest chip's word sits at the MSB end so it leaves first and ends up furthest down the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_tcnt   <= '0;
      r_shift  <= '0;
      r_mosi   <= 1'b0;
      r_sclk   <= 1'b0;
      r_sel    <= 1'b1;
      r_busy   <= 1'b0;
    end else if (w_fstart) begin
      r_active <= 1'b1;
      r_tcnt   <= '0;
      r_shift  <= w_frame;
      r_sel    <= 1'b0;
      r_busy   <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
    end else if (w_tick && r_active) begin
      r_tcnt <= r_tcnt + TW'(1);
      if (r_tcnt < TW'(32*CHIPS)) begin
        if (!r_tcnt[0]) begin
          r_sclk <= 1'b0;
          r_mosi <= r_shift[FW-1];
        end else begin
          r_sclk  <= 1'b1;
          r_shift <= r_shift << 1;
        end
      end else if (r_tcnt == TW'(32*CHIPS)) begin
        r_sclk <= 1'b0;
        r_mosi <= 1'b0;
      end else begin
        r_sel    <= 1'b1;
        r_busy   <= 1'b0;
        r_active <= 1'b0;
      end
    end
  end

  assign mosi = r_mosi;
  assign sclk = r_sclk;
  assign sel  = r_sel;
  assign busy = r_busy;
endmodule
